// File: rtl/load_ext_pkg.sv
// Shared types and helpers for the load-writeback extend pipeline.
// Holds the access-size encoding, the size/alignment helpers and the
// stage payload layout used at the default 64-bit / 6-bit-tag configuration.
package load_ext_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_TAG_WIDTH  = 6;

  // Access size as log2 of the byte count.
  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  // Stage payload at the default configuration; the top builds the same
  // layout from its own parameters so other widths stay consistent.
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] data;
    logic [1:0]                size;
    logic                      sgn;
    logic [DEF_TAG_WIDTH-1:0]  tag;
    logic                      err;
  } stage_t;

  function automatic int size_bytes(input int size);
    return 1 << size;
  endfunction

  // Offset alignment only: the field must fit between offset and the top
  // byte of the word. Wrapping past the top byte is an error, never a rotate.
  // An access wider than the word is caught by the first term.
  function automatic logic is_misaligned(input int offset, input int size,
                                         input int data_width);
    int nbytes;
    nbytes = data_width / 8;
    return (size_bytes(size) > nbytes) || (offset + size_bytes(size) > nbytes);
  endfunction

endpackage

// File: rtl/pipe_slice.sv
// Single elastic register slice with flush, parameterised by payload width.
// Latency 1 cycle; full throughput (ready = empty or downstream draining).
// Backpressure: in_ready drops only when full and out_ready is low; 0 in reset.
// Ports: clk, rst_n (sync, active-low), flush, in_valid/in_ready/in_pay,
//        out_valid/out_ready/out_pay.
module pipe_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_pay,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_pay
);

  logic         vld_q;
  logic [W-1:0] pay_q;

  assign in_ready  = rst_n && (!vld_q || out_ready);
  assign out_valid = vld_q;
  assign out_pay   = pay_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      pay_q <= '0;
    end else if (flush) begin
      // An accepting handshake during flush is dropped, not stalled.
      vld_q <= 1'b0;
    end else if (in_ready) begin
      vld_q <= in_valid;
      // Payload only moves with a real entry so idle inputs never leak in.
      if (in_valid) pay_q <= in_pay;
    end
  end

endmodule

// File: rtl/load_extend_pipe.sv
// Load-writeback align + sign/zero-extend pipeline carrying a ROB tag.
// Latency 2 register stages (align slice, extend slice); 1 result/cycle.
// Backpressure: elastic valid/ready, in_ready = !s1_valid || s1_advance.
// Ports: clk, rst_n (sync, active-low), flush; in_valid/in_ready with
//        in_data/in_offset/in_size/in_signed/in_tag; out_valid/out_ready with
//        out_data/out_tag/out_err (err forces out_data to zero).
module load_extend_pipe
  import load_ext_pkg::*;
#(
  parameter  int DATA_WIDTH = 64,
  parameter  int TAG_WIDTH  = 6,
  localparam int OFF_WIDTH  = $clog2(DATA_WIDTH / 8),
  localparam int SIZE_WIDTH = $clog2($clog2(DATA_WIDTH / 8) + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [OFF_WIDTH-1:0]  in_offset,
  input  logic [SIZE_WIDTH-1:0] in_size,
  input  logic                  in_signed,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_err
);

  localparam int LOG2B = OFF_WIDTH;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [SIZE_WIDTH-1:0] size;
    logic                  sgn;
    logic [TAG_WIDTH-1:0]  tag;
    logic                  err;
  } s1_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0]  tag;
    logic                  err;
  } s2_t;

  s1_t  s1_in, s1_q;
  s2_t  s2_in, s2_q;
  logic s1_valid, s1_advance;

  // Stage 1: bring the addressed field down to bit 0.
  always_comb begin
    s1_in      = '0;
    s1_in.data = in_data >> {in_offset, 3'b000};
    s1_in.size = in_size;
    s1_in.sgn  = in_signed;
    s1_in.tag  = in_tag;
    s1_in.err  = is_misaligned(int'(in_offset), int'(in_size), DATA_WIDTH);
  end

  pipe_slice #(.W($bits(s1_t))) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pay    (s1_in),
    .out_valid (s1_valid),
    .out_ready (s1_advance),
    .out_pay   (s1_q)
  );

  // Stage 2: one extension candidate per legal sub-word size, then select.
  logic [DATA_WIDTH-1:0] ext_opt [LOG2B+1];
  logic [DATA_WIDTH-1:0] ext;

  for (genvar g = 0; g < LOG2B; g++) begin : g_ext
    localparam int FW = 8 << g;
    assign ext_opt[g] = s1_q.sgn ? {{(DATA_WIDTH-FW){s1_q.data[FW-1]}}, s1_q.data[FW-1:0]}
                                 : {{(DATA_WIDTH-FW){1'b0}}, s1_q.data[FW-1:0]};
  end
  // Full-width access passes through regardless of signedness.
  assign ext_opt[LOG2B] = s1_q.data;

  always_comb begin
    ext = '0;
    for (int i = 0; i <= LOG2B; i++) begin
      if (s1_q.size == SIZE_WIDTH'(i)) ext = ext_opt[i];
    end
  end

  always_comb begin
    s2_in      = '0;
    s2_in.data = s1_q.err ? '0 : ext;
    s2_in.tag  = s1_q.tag;
    s2_in.err  = s1_q.err;
  end

  pipe_slice #(.W($bits(s2_t))) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (s1_valid),
    .in_ready  (s1_advance),
    .in_pay    (s2_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pay   (s2_q)
  );

  assign out_data = s2_q.data;
  assign out_tag  = s2_q.tag;
  assign out_err  = s2_q.err;

endmodule

// File: tb/tb_load_extend_pipe.sv
module tb_load_extend_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [2:0]  in_offset;
  logic [1:0]  in_size;
  logic        in_signed;
  logic [5:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [5:0]  out_tag;
  logic        out_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_extend_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_offset (in_offset),
    .in_size   (in_size),
    .in_signed (in_signed),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_err   (out_err)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] d, input logic [2:0] off, input logic [1:0] sz,
                       input logic sg, input logic [5:0] tg);
    in_valid  = 1'b1;
    in_data   = d;
    in_offset = off;
    in_size   = sz;
    in_signed = sg;
    in_tag    = tg;
  endtask

  // Present one request, check it is absent after the accepting edge and
  // present with the expected payload after the next edge, then drain it.
  task automatic one(input string name, input logic [63:0] d, input logic [2:0] off,
                     input logic [1:0] sz, input logic sg, input logic [5:0] tg,
                     input logic [63:0] exp_d, input logic exp_e);
    out_ready = 1'b1;
    drive(d, off, sz, sg, tg);
    #1;
    chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk({name, "_early"}, 64'(out_valid), 64'd0);
    step();
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_data"}, out_data, exp_d);
    chk({name, "_tag"}, 64'(out_tag), 64'(tg));
    chk({name, "_err"}, 64'(out_err), 64'(exp_e));
    step();
  endtask

  initial begin
    int         next_tag;
    int         exp_tag;
    logic       held_vld;
    logic [5:0] held_tag;
    logic [63:0] held_data;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_offset = '0; in_size = '0; in_signed = 1'b0; in_tag = '0;

    // Reset state
    step(); step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    step();

    // Directed extension vectors
    one("byte_s",   64'h0000_0000_8000_0000, 3'd3, 2'd0, 1'b1, 6'd5, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    one("half_u",   64'h0000_0000_0000_F00D, 3'd0, 2'd1, 1'b0, 6'd6, 64'h0000_0000_0000_F00D, 1'b0);
    one("half_s",   64'h0000_0000_0000_F00D, 3'd0, 2'd1, 1'b1, 6'd7, 64'hFFFF_FFFF_FFFF_F00D, 1'b0);
    one("word_mis", 64'hDEAD_BEEF_CAFE_F00D, 3'd6, 2'd2, 1'b1, 6'd9, 64'h0, 1'b1);
    one("half_off1",64'h0000_0000_00AB_CD00, 3'd1, 2'd1, 1'b1, 6'd10, 64'hFFFF_FFFF_FFFF_ABCD, 1'b0);
    one("half_wrap",64'h1234_0000_0000_0000, 3'd7, 2'd1, 1'b0, 6'd11, 64'h0, 1'b1);
    one("byte_top", 64'h7F00_0000_0000_0000, 3'd7, 2'd0, 1'b1, 6'd12, 64'h0000_0000_0000_007F, 1'b0);
    one("word_s",   64'h8765_4321_0000_0000, 3'd4, 2'd2, 1'b1, 6'd13, 64'hFFFF_FFFF_8765_4321, 1'b0);
    one("word_u",   64'h8765_4321_0000_0000, 3'd4, 2'd2, 1'b0, 6'd14, 64'h0000_0000_8765_4321, 1'b0);
    one("dword_s",  64'h8123_4567_89AB_CDEF, 3'd0, 2'd3, 1'b1, 6'd15, 64'h8123_4567_89AB_CDEF, 1'b0);
    one("dword_mis",64'h8123_4567_89AB_CDEF, 3'd1, 2'd3, 1'b0, 6'd16, 64'h0, 1'b1);

    // Backpressure: tags 1..4, consumer stalls in cycles 3..6
    next_tag = 1; exp_tag = 1; held_vld = 1'b0; held_tag = '0; held_data = '0;
    for (int c = 0; c < 12; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      if (next_tag <= 4) drive(64'(next_tag), 3'd0, 2'd0, 1'b0, 6'(next_tag));
      else in_valid = 1'b0;
      #1;
      if (c == 2) chk("bp_rdy_open", 64'(in_ready), 64'd1);
      if (c == 3) chk("bp_rdy_full", 64'(in_ready), 64'd0);
      if (held_vld) begin
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
        chk("bp_hold_tag", 64'(out_tag), 64'(held_tag));
        chk("bp_hold_data", out_data, held_data);
      end
      if (out_valid && out_ready) begin
        chk("bp_order", 64'(out_tag), 64'(exp_tag));
        chk("bp_data", out_data, 64'(exp_tag));
        exp_tag++;
      end
      held_vld  = out_valid && !out_ready;
      held_tag  = out_tag;
      held_data = out_data;
      if (in_valid && in_ready) next_tag++;
      step();
    end
    in_valid = 1'b0;
    chk("bp_count", 64'(exp_tag), 64'd5);
    chk("bp_sent", 64'(next_tag), 64'd5);

    // Flush with a held result and a second entry in flight
    out_ready = 1'b0;
    drive(64'h11, 3'd0, 2'd0, 1'b0, 6'd20); step();
    drive(64'h22, 3'd0, 2'd0, 1'b0, 6'd21); step();
    in_valid = 1'b0;
    chk("fl_full", 64'(out_valid), 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    out_ready = 1'b1;
    chk("fl_discard", 64'(out_valid), 64'd0);
    // Request accepted in the same cycle as flush is dropped, not stalled
    flush = 1'b1;
    drive(64'h33, 3'd0, 2'd0, 1'b0, 6'd22);
    #1;
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("fl_quiet", 64'(out_valid), 64'd0);
      step();
    end
    one("fl_after", 64'h0000_0000_0000_00C3, 3'd0, 2'd0, 1'b1, 6'd23, 64'hFFFF_FFFF_FFFF_FFC3, 1'b0);

    // Reset mid-stream with both stages full
    out_ready = 1'b0;
    drive(64'hAAAA_BBBB_CCCC_DDDD, 3'd6, 2'd2, 1'b0, 6'd30); step();
    drive(64'h0000_0000_0000_0055, 3'd0, 2'd0, 1'b0, 6'd31); step();
    in_valid = 1'b0;
    #1;
    chk("mr_full_valid", 64'(out_valid), 64'd1);
    chk("mr_full_err", 64'(out_err), 64'd1);
    chk("mr_full_rdy", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    step();
    chk("mr_valid", 64'(out_valid), 64'd0);
    chk("mr_data", out_data, 64'd0);
    chk("mr_tag", 64'(out_tag), 64'd0);
    chk("mr_err", 64'(out_err), 64'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("mr_rel_rdy", 64'(in_ready), 64'd1);
    step();
    chk("mr_s1_clear", 64'(out_valid), 64'd0);
    step();
    chk("mr_quiet", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
